// File: rtl/lif_neuron_array_if.sv
// Bus bundle for lif_neuron_array: timestep control, input current stream,
// per-neuron spike results, end-of-step summary and an FSM debug tap.
interface lif_neuron_array_if #(
   parameter int DATA_W      = 16,
   parameter int NUM_NEURONS = 4
);
   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam int CNT_W = $clog2(NUM_NEURONS + 1);

   // Input stream: a beat transfers on a rising clk edge where in_valid and
   // in_ready are both high; in_current must hold steady while in_valid waits.
   logic              step_start;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_current;
   logic              spike_valid;
   logic              spike;
   logic [IDX_W-1:0]  spike_idx;
   logic [DATA_W-1:0] v_out;
   logic              step_done;
   logic [CNT_W-1:0]  step_spike_count;
   logic [1:0]        dbg_state;

   modport master (
      output step_start, in_valid, in_current,
      input  in_ready, spike_valid, spike, spike_idx, v_out,
             step_done, step_spike_count, dbg_state
   );

   modport slave (
      input  step_start, in_valid, in_current,
      output in_ready, spike_valid, spike, spike_idx, v_out,
             step_done, step_spike_count, dbg_state
   );
endinterface

// File: rtl/lif_neuron_array.sv
// Time-multiplexed leaky integrate-and-fire neuron array sharing one update datapath.
// Optional adaptive threshold is enabled with the LIF_ADAPT_EN macro.
module lif_neuron_array #(
   parameter int NUM_NEURONS       = 4,
   parameter int DATA_W            = 16,
   parameter int THRESHOLD         = 1000,
   parameter int REST_POTENTIAL    = 650,
   parameter int RESET_POTENTIAL   = 600,
   parameter int LEAK_SHIFT        = 4,
   parameter int REFRACTORY_PERIOD = 2,
   parameter int ADAPT_INC         = 50
) (
   input logic                clk,
   input logic                rst,
   lif_neuron_array_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_NEURONS);
   localparam int CNT_W = $clog2(NUM_NEURONS + 1);
   localparam int REF_W = (REFRACTORY_PERIOD > 0) ? $clog2(REFRACTORY_PERIOD + 1) : 1;

   localparam logic [DATA_W-1:0] P_MAX   = '1;
   localparam logic [DATA_W-1:0] P_REST  = DATA_W'(REST_POTENTIAL);
   localparam logic [DATA_W-1:0] P_RESET = DATA_W'(RESET_POTENTIAL);
   localparam logic [DATA_W-1:0] P_THR   = DATA_W'(THRESHOLD);
   localparam logic [REF_W-1:0]  P_REF   = REF_W'(REFRACTORY_PERIOD);
   localparam logic [IDX_W-1:0]  P_LAST  = IDX_W'(NUM_NEURONS - 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t            r_state;
   logic [IDX_W-1:0]  r_idx;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_step_cnt;
   logic              r_in_ready;
   logic              r_spike_valid;
   logic              r_spike;
   logic [IDX_W-1:0]  r_spike_idx;
   logic [DATA_W-1:0] r_v_out;
   logic              r_step_done;
   logic [DATA_W-1:0] r_v   [NUM_NEURONS];
   logic [REF_W-1:0]  r_ref [NUM_NEURONS];

   logic              w_accept;
   logic              w_fire;
   logic [DATA_W-1:0] w_v, w_vl, w_vn, w_v_next, w_thr;
   logic [DATA_W:0]   w_sum;
   logic [REF_W-1:0]  w_r, w_r_next;
`ifdef LIF_ADAPT_EN
   logic [DATA_W-1:0] r_a [NUM_NEURONS];
   logic [DATA_W-1:0] w_a, w_a_next;
   logic [DATA_W:0]   w_thr_sum, w_a_sum;
`endif

   assign w_accept = r_in_ready && bus.in_valid;

   always_comb begin
      w_v = r_v[r_idx];
      w_r = r_ref[r_idx];
      if (w_v > P_REST)
         w_vl = w_v - ((w_v - P_REST) >> LEAK_SHIFT);
      else if (w_v < P_REST)
         w_vl = w_v + ((P_REST - w_v) >> LEAK_SHIFT);
      else
         w_vl = w_v;
      w_sum = {1'b0, w_vl} + {1'b0, bus.in_current};
      w_vn  = w_sum[DATA_W] ? P_MAX : w_sum[DATA_W-1:0];
`ifdef LIF_ADAPT_EN
      w_a       = r_a[r_idx];
      w_thr_sum = {1'b0, P_THR} + {1'b0, w_a};
      w_thr     = w_thr_sum[DATA_W] ? P_MAX : w_thr_sum[DATA_W-1:0];
      w_a_sum   = {1'b0, w_a} + (DATA_W + 1)'(ADAPT_INC);
`else
      w_thr = P_THR;
`endif
      w_fire = (w_r == '0) && (w_vn >= w_thr);
      if (w_r != '0) begin
         w_v_next = P_RESET;
         w_r_next = w_r - REF_W'(1);
      end else if (w_fire) begin
         w_v_next = P_RESET;
         w_r_next = P_REF;
      end else begin
         w_v_next = w_vn;
         w_r_next = '0;
      end
`ifdef LIF_ADAPT_EN
      if (w_r != '0)
         w_a_next = w_a;
      else if (w_fire)
         w_a_next = w_a_sum[DATA_W] ? P_MAX : w_a_sum[DATA_W-1:0];
      else if (w_a != '0)
         w_a_next = w_a - DATA_W'(1);
      else
         w_a_next = w_a;
`endif
   end

   // Per-neuron state: only the addressed entry changes on an accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_v[i]   <= P_REST;
            r_ref[i] <= '0;
`ifdef LIF_ADAPT_EN
            r_a[i]   <= '0;
`endif
         end
      end else if (w_accept) begin
         r_v[r_idx]   <= w_v_next;
         r_ref[r_idx] <= w_r_next;
`ifdef LIF_ADAPT_EN
         r_a[r_idx]   <= w_a_next;
`endif
      end
   end

   // step_done is registered out of DONE, so it lands one cycle after the last result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_idx         <= '0;
         r_cnt         <= '0;
         r_step_cnt    <= '0;
         r_in_ready    <= 1'b0;
         r_spike_valid <= 1'b0;
         r_spike       <= 1'b0;
         r_spike_idx   <= '0;
         r_v_out       <= '0;
         r_step_done   <= 1'b0;
      end else begin
         r_spike_valid <= w_accept;
         r_spike       <= w_accept && w_fire;
         r_spike_idx   <= w_accept ? r_idx : '0;
         r_v_out       <= w_accept ? w_v_next : '0;
         r_step_done   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.step_start) begin
                  r_state    <= S_RUN;
                  r_idx      <= '0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b1;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_fire)
                     r_cnt <= r_cnt + CNT_W'(1);
                  if (r_idx == P_LAST) begin
                     r_state    <= S_DONE;
                     r_idx      <= '0;
                     r_in_ready <= 1'b0;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end
            end
            S_DONE: begin
               r_state     <= S_IDLE;
               r_step_done <= 1'b1;
               r_step_cnt  <= r_cnt;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready         = r_in_ready;
   assign bus.spike_valid      = r_spike_valid;
   assign bus.spike            = r_spike;
   assign bus.spike_idx        = r_spike_idx;
   assign bus.v_out            = r_v_out;
   assign bus.step_done        = r_step_done;
   assign bus.step_spike_count = r_step_cnt;
   assign bus.dbg_state        = r_state;
endmodule

// File: tb/tb_lif_neuron_array.sv
// Directed table-driven bench for lif_neuron_array; expected potentials are hand-computed.
// Build with LIF_ADAPT_EN defined to check the adaptive-threshold variant.
module tb_lif_neuron_array;
   localparam int DW = 16;
   localparam int NN = 4;

   typedef struct packed {
      logic [3:0][15:0] cur;
      logic [3:0]       spk;
      logic [3:0][15:0] v;
      logic [2:0]       cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lif_neuron_array_if #(.DATA_W(DW), .NUM_NEURONS(NN)) bus ();
   lif_neuron_array #(.NUM_NEURONS(NN), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [18:0] exp_q[$];
   logic [2:0]  exp_cnt_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_res_cyc = 0;
   int step_res = 0;
   int done_seen = 0;
   vec_t tbl[10];

   // Monitor / scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      logic [18:0] got, e;
      logic [2:0]  ec;
      cyc++;
      if (rst) step_res = 0;
      if (bus.spike_valid) begin
         got = {bus.spike_idx, bus.spike, bus.v_out};
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL result_unexpected got idx=%0d spike=%0d v=%0d", got[18:17], got[16], got[15:0]);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               bad++;
               $display("FAIL result got idx=%0d spike=%0d v=%0d want idx=%0d spike=%0d v=%0d",
                        got[18:17], got[16], got[15:0], e[18:17], e[16], e[15:0]);
            end
         end
         step_res++;
         last_res_cyc = cyc;
      end
      if (bus.step_done) begin
         total++;
         if (exp_cnt_q.size() == 0) begin
            bad++;
            $display("FAIL step_done_unexpected count=%0d", bus.step_spike_count);
         end else begin
            ec = exp_cnt_q.pop_front();
            if (bus.step_spike_count !== ec) begin
               bad++;
               $display("FAIL step_count got %0d want %0d", bus.step_spike_count, ec);
            end
         end
         total++;
         if (step_res != NN) begin
            bad++;
            $display("FAIL step_beats got %0d want %0d", step_res, NN);
         end
         total++;
         if (cyc != last_res_cyc + 1) begin
            bad++;
            $display("FAIL done_latency got %0d want %0d", cyc - last_res_cyc, 1);
         end
         step_res = 0;
         done_seen++;
      end
   end

   function automatic vec_t mk(int c0, int c1, int c2, int c3, logic [3:0] s,
                               int v0, int v1, int v2, int v3, int cnt);
      vec_t r;
      r.cur[0] = 16'(c0); r.cur[1] = 16'(c1); r.cur[2] = 16'(c2); r.cur[3] = 16'(c3);
      r.spk = s;
      r.v[0] = 16'(v0); r.v[1] = 16'(v1); r.v[2] = 16'(v2); r.v[3] = 16'(v3);
      r.cnt = 3'(cnt);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [15:0] c);
      logic acc;
      acc = 1'b0;
      bus.in_valid   = 1'b1;
      bus.in_current = c;
      for (int k = 0; k < 20; k++) begin
         acc = bus.in_ready;
         tick();
         if (acc) break;
      end
      bus.in_valid = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL beat_timeout got in_ready=0 want 1");
      end
   endtask

   task automatic wait_done();
      int d0;
      d0 = done_seen;
      for (int k = 0; k < 10; k++) begin
         if (done_seen != d0) break;
         tick();
      end
      if (done_seen == d0) begin
         total++;
         bad++;
         $display("FAIL done_timeout got no step_done want step_done");
      end
   endtask

   task automatic push_exp(input vec_t v, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back({2'(i), v.spk[i], v.v[i]});
   endtask

   task automatic run_vec(input vec_t v, input bit gaps);
      push_exp(v, NN);
      exp_cnt_q.push_back(v.cnt);
      bus.step_start = 1'b1;
      tick();
      bus.step_start = 1'b0;
      for (int i = 0; i < NN; i++) begin
         if (gaps && i == 2) begin
            tick();
            bus.step_start = 1'b1;
            tick();
            bus.step_start = 1'b0;
            tick();
         end
         send_beat(v.cur[i]);
      end
      wait_done();
      tick();
   endtask

   task automatic check_idle(input string name);
      logic [29:0] got;
      @(negedge clk);
      got = {bus.spike_valid, bus.spike, bus.spike_idx, bus.v_out, bus.step_done,
             bus.step_spike_count, bus.in_ready, bus.dbg_state};
      total++;
      if (got !== '0) begin
         bad++;
         $display("FAIL %s got outputs=%h want 0", name, got);
      end
      tick();
   endtask

   initial begin
      vec_t partial;
      bus.step_start = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_current = '0;

      tbl[0] = mk(0, 0, 0, 0, 4'b0000, 650, 650, 650, 650, 0);
      tbl[1] = mk(400, 250, 0, 0, 4'b0001, 600, 900, 650, 650, 1);
      tbl[2] = mk(400, 0, 65535, 0, 4'b0100, 600, 885, 600, 650, 1);
      tbl[3] = mk(400, 0, 0, 0, 4'b0000, 600, 871, 600, 650, 0);
      tbl[4] = mk(390, 0, 0, 0, 4'b0000, 993, 858, 600, 650, 0);
      tbl[5] = mk(0, 0, 0, 400, 4'b1000, 972, 845, 603, 600, 1);
      tbl[6] = mk(0, 0, 0, 400, 4'b0000, 952, 833, 605, 600, 0);
      tbl[7] = mk(0, 0, 0, 400, 4'b0000, 934, 822, 607, 600, 0);
`ifdef LIF_ADAPT_EN
      tbl[8] = mk(0, 0, 0, 400, 4'b0000, 917, 812, 609, 1003, 0);
      tbl[9] = mk(0, 0, 0, 0, 4'b0000, 901, 802, 611, 981, 0);
`else
      tbl[8] = mk(0, 0, 0, 400, 4'b1000, 917, 812, 609, 600, 1);
      tbl[9] = mk(0, 0, 0, 0, 4'b0000, 901, 802, 611, 600, 0);
`endif

      repeat (3) tick();
      rst = 1'b0;
      check_idle("reset_state");

      for (int t = 0; t < 9; t++)
         run_vec(tbl[t], 1'b0);

      // Stalls plus a stray step_start while running.
      run_vec(tbl[9], 1'b1);

      // Reset after two accepted beats: partial step is discarded.
      partial = mk(0, 0, 0, 0, 4'b0000, 886, 793, 0, 0, 0);
      push_exp(partial, 2);
      bus.step_start = 1'b1;
      tick();
      bus.step_start = 1'b0;
      send_beat(16'd0);
      send_beat(16'd0);
      tick();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      check_idle("mid_step_reset");
      repeat (5) tick();

      // Fresh potentials after reset, including an exact-threshold hit.
      run_vec(mk(0, 350, 0, 349, 4'b0010, 650, 600, 650, 999, 1), 1'b0);

      repeat (4) tick();
      total++;
      if (exp_q.size() != 0 || exp_cnt_q.size() != 0) begin
         bad++;
         $display("FAIL leftover got results=%0d counts=%0d want 0", exp_q.size(), exp_cnt_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
